// File: rtl/wrapper_packet_assemble.sv
// wrapper_packet_assemble
//
// Converts register-bus writes into fixed-width packets on a valid/ready
// stream. Writes merge byte-wise into a construction buffer. A write to the
// last word of a packet pushes the completed packet into a first-word-fall-
// through output FIFO.
//
// Optional feature macro: WRAPPER_PKT_JUMP_FLUSH_EN
//   defined   : a write to a different packet address while the buffer holds
//               partial data first flushes the partial packet. wready is low
//               for that cycle.
//   undefined : the partial buffer is discarded, and the new write is merged
//               into the cleared buffer.
//
// Ports
//   hclk, hresetn       clock, asynchronous active-low reset
//   addr                register byte address
//   read_en / rdata     combinational read of the buffer word at addr
//   write_en, byte_strobe, wdata, wready
//                       register write. It is accepted when wready is high.
//   rready              always 1
//   packet_data, packet_data_last, packet_data_valid, packet_data_ready
//                       output stream showing the FIFO head
//   constructor_ready   FIFO not full
//   fifo_level          FIFO occupancy
module wrapper_packet_assemble #(
    parameter int ADDRWIDTH   = 11,
    parameter int REGDWIDTH   = 32,
    parameter int PACKETWIDTH = 512,
    parameter int DEPTH       = 2
) (
    input  logic                         hclk,
    input  logic                         hresetn,
    input  logic [ADDRWIDTH-1:0]         addr,
    input  logic                         read_en,
    input  logic                         write_en,
    input  logic [REGDWIDTH/8-1:0]       byte_strobe,
    input  logic [REGDWIDTH-1:0]         wdata,
    output logic [REGDWIDTH-1:0]         rdata,
    output logic                         wready,
    output logic                         rready,
    output logic [PACKETWIDTH-1:0]       packet_data,
    output logic                         packet_data_last,
    output logic                         packet_data_valid,
    input  logic                         packet_data_ready,
    output logic                         constructor_ready,
    output logic [$clog2(DEPTH+1)-1:0]   fifo_level
);

    localparam int NB   = REGDWIDTH / 8;
    localparam int WB   = $clog2(NB);
    localparam int PB   = $clog2(PACKETWIDTH / 8);
    localparam int PAW  = ADDRWIDTH - PB;
    localparam int PTRW = $clog2(DEPTH);
    localparam int LVW  = $clog2(DEPTH + 1);

    // Construction state
    logic [PACKETWIDTH-1:0] r_buf;
    logic [PAW-1:0]         r_cur_pkt_addr;
    logic                   r_dirty;

    // FIFO state
    logic [PACKETWIDTH-1:0] r_mem      [DEPTH];
    logic                   r_mem_last [DEPTH];
    logic [PTRW-1:0]        r_wr_ptr;
    logic [PTRW-1:0]        r_rd_ptr;
    logic [LVW-1:0]         r_level;
    logic [PACKETWIDTH-1:0] r_hold;       // last popped head, shown while empty
    logic                   r_hold_last;

    logic [PB-WB-1:0]       w_widx;
    logic [PAW-1:0]         w_paddr;
    logic [WB-1:0]          w_unused_addr_lsb;
    logic                   w_full;
    logic                   w_empty;
    logic                   w_jump;
    logic                   w_last_word;
    logic                   w_wr_acc;
    logic                   w_flush_push;
    logic                   w_emit;
    logic                   w_push;
    logic                   w_pop;
    logic                   w_push_last;
    logic [PACKETWIDTH-1:0] w_base;
    logic [PACKETWIDTH-1:0] w_buf_new;
    logic [PACKETWIDTH-1:0] w_push_data;
    logic [REGDWIDTH-1:0]   w_old_word;
    logic [REGDWIDTH-1:0]   w_merged;

    assign w_widx            = addr[PB-1:WB];
    assign w_paddr           = addr[ADDRWIDTH-1:PB];
    assign w_unused_addr_lsb = addr[WB-1:0];

    assign w_full      = (r_level == LVW'(DEPTH));
    assign w_empty     = (r_level == '0);
    assign w_jump      = write_en && r_dirty && (w_paddr != r_cur_pkt_addr);
    assign w_last_word = &w_widx;

`ifdef WRAPPER_PKT_JUMP_FLUSH_EN
    // A jump holds the write for one cycle while the partial packet is pushed.
    assign w_flush_push = w_jump && !w_full;
    assign w_wr_acc     = write_en && !w_jump && !(w_last_word && w_full);
    assign w_base       = r_buf;
`else
    // A jump drops the partial packet and merges into a cleared buffer.
    assign w_flush_push = 1'b0;
    assign w_wr_acc     = write_en && !(w_last_word && w_full);
    assign w_base       = w_jump ? '0 : r_buf;
`endif

    // The stall ignores a same-cycle pop, so wready depends only on state.
    assign wready = !write_en || w_wr_acc;
    assign rready = 1'b1;

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        w_old_word = w_base[REGDWIDTH*int'(w_widx) +: REGDWIDTH];
        w_merged   = w_old_word;
        for (int b = 0; b < NB; b++) begin
            if (byte_strobe[b]) w_merged[b*8 +: 8] = wdata[b*8 +: 8];
        end
        w_buf_new = w_base;
        w_buf_new[REGDWIDTH*int'(w_widx) +: REGDWIDTH] = w_merged;
    end

    assign rdata = read_en ? r_buf[REGDWIDTH*int'(w_widx) +: REGDWIDTH] : '0;

    assign w_emit      = w_wr_acc && w_last_word;
    assign w_push      = w_emit || w_flush_push;
    assign w_push_data = w_flush_push ? r_buf
                                      : {w_merged, w_base[PACKETWIDTH-REGDWIDTH-1:0]};
    assign w_push_last = w_flush_push ? (&r_cur_pkt_addr) : (&w_paddr);
    assign w_pop       = packet_data_valid && packet_data_ready;

    // Construction buffer
    // NOTE: sequential state uses non-blocking assignments only, so every
    // flop samples pre-edge values.
    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            r_buf          <= '0;
            r_cur_pkt_addr <= '0;
            r_dirty        <= 1'b0;
        end else if (w_flush_push) begin
            r_buf   <= '0;
            r_dirty <= 1'b0;
        end else if (w_wr_acc) begin
            r_cur_pkt_addr <= w_paddr;
            if (w_emit) begin
                r_buf   <= '0;
                r_dirty <= 1'b0;
            end else begin
                r_buf   <= w_buf_new;
                r_dirty <= 1'b1;
            end
        end
    end

    function automatic logic [PTRW-1:0] ptr_inc(input logic [PTRW-1:0] p);
        return (p == PTRW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Output FIFO
    // NOTE: the storage array is reset as well. A reset therefore discards
    // every queued packet, and the head reads 0 afterwards.
    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i]      <= '0;
                r_mem_last[i] <= 1'b0;
            end
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_level     <= '0;
            r_hold      <= '0;
            r_hold_last <= 1'b0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr]      <= w_push_data;
                r_mem_last[r_wr_ptr] <= w_push_last;
                r_wr_ptr             <= ptr_inc(r_wr_ptr);
            end
            if (w_pop) begin
                r_hold      <= r_mem[r_rd_ptr];
                r_hold_last <= r_mem_last[r_rd_ptr];
                r_rd_ptr    <= ptr_inc(r_rd_ptr);
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end

    assign packet_data       = w_empty ? r_hold      : r_mem[r_rd_ptr];
    assign packet_data_last  = w_empty ? r_hold_last : r_mem_last[r_rd_ptr];
    assign packet_data_valid = !w_empty;
    assign constructor_ready = !w_full;
    assign fifo_level        = r_level;

endmodule
